// File: rtl/prm_sweep_pkg.sv
// prm_sweep_pkg
// Shared types and constants for the roadmap edge-sweep controller.
//   CODE_W     : edge-code width fixed by the obstacle-logic checker bank (inputs A..O)
//   state_t    : sweep sequencer states
//   res_t      : one per-edge result as stored in the result FIFO
//   last_idx() : index of the final edge of a sweep of n edges
package prm_sweep_pkg;

  localparam int CODE_W = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] addr;
    logic              blocked;
  } res_t;

  function automatic logic [CODE_W-1:0] last_idx(input logic [CODE_W-1:0] n);
    return n - CODE_W'(1);
  endfunction

endpackage

// File: rtl/prm_edge_sweep_ctrl_if.sv
// prm_edge_sweep_ctrl_if
// Bundles the host command path, the checker-bank link and the result stream of the
// edge-sweep controller.
//   master : host + checker bank side (drives start/abort/config, chk_mask, res_ready)
//   slave  : the controller (drives chk_code, res_*, busy, done)
// Signals:
//   start, abort        command pulses
//   edge_count, obs_en  sweep configuration, sampled on an accepted start
//   chk_code / chk_mask edge code out to the bank, per-checker edge_mask back
//   res_valid/res_ready result handshake; res_addr, res_blocked result payload
//   busy, done          sweep status
interface prm_edge_sweep_ctrl_if
  import prm_sweep_pkg::*;
#(
  parameter int NCHK = 32
) ();

  logic              start;
  logic              abort;
  logic [CODE_W-1:0] edge_count;
  logic [NCHK-1:0]   obs_en;
  logic [CODE_W-1:0] chk_code;
  logic [NCHK-1:0]   chk_mask;
  logic              res_valid;
  logic              res_ready;
  logic [CODE_W-1:0] res_addr;
  logic              res_blocked;
  logic              busy;
  logic              done;

  modport master (
    output start, abort, edge_count, obs_en, chk_mask, res_ready,
    input  chk_code, res_valid, res_addr, res_blocked, busy, done
  );

  modport slave (
    input  start, abort, edge_count, obs_en, chk_mask, res_ready,
    output chk_code, res_valid, res_addr, res_blocked, busy, done
  );

endinterface

// File: rtl/prm_res_fifo.sv
// prm_res_fifo
// Synchronous result FIFO with a synchronous clear.
//   i_clk   : clock, rising edge
//   i_clr   : synchronous clear (empties the FIFO and zeroes storage)
//   i_push  : write i_din (ignored when full with no simultaneous pop)
//   i_din   : write data
//   i_pop   : remove the head entry (ignored when empty)
//   o_dout  : head entry
//   o_full  : DEPTH entries held
//   o_empty : no entries held
//   o_count : current occupancy
module prm_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_din,
  input  logic          i_pop,
  output logic [W-1:0]  o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // Pointers wrap explicitly so any depth works, not only powers of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? AW'(0) : p + AW'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != CW'(0));
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  // Storage, pointers and occupancy; storage is zeroed on clear so the head reads 0 when empty
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= CW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == CW'(0));
  assign o_count = r_count;

endmodule

// File: rtl/prm_edge_sweep_ctrl.sv
// prm_edge_sweep_ctrl
// Walks every roadmap edge index through one shared bank of obstacle-logic checkers and
// streams a blocked/free verdict per edge, in edge order, to the pruning stage.
// Ports:
//   CLK   : clock, rising edge
//   RST   : synchronous reset, active-high
//   sweep : prm_edge_sweep_ctrl_if.slave (command, checker-bank link, result stream, status)
// Parameters:
//   NCHK    : checkers in the bank
//   CHK_LAT : cycles from chk_code to the matching chk_mask (0..3)
//   FIFO_D  : result FIFO depth, must be >= CHK_LAT+1
module prm_edge_sweep_ctrl
  import prm_sweep_pkg::*;
#(
  parameter int NCHK    = 32,
  parameter int CHK_LAT = 1,
  parameter int FIFO_D  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  prm_edge_sweep_ctrl_if.slave   sweep
);

  localparam int OCC_W = $clog2(FIFO_D + 1);

  state_t            r_state;
  state_t            w_state_seq;
  state_t            w_state_nxt;
  logic [CODE_W-1:0] r_idx;
  logic [CODE_W-1:0] r_cnt;
  logic [NCHK-1:0]   r_obs;
  logic [CODE_W-1:0] r_chk_code;
  logic              r_busy;
  logic              r_done;

  // Tag pipe: stage 0 holds the code currently on chk_code, stage CHK_LAT lines up with chk_mask.
  logic              r_pv [CHK_LAT+1];
  logic [CODE_W-1:0] r_pt [CHK_LAT+1];

  logic              w_clr;
  logic              w_accept_start;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_inflight;
  logic [7:0]        w_used;
  logic [7:0]        w_limit;
  res_t              w_res_in;
  res_t              w_head;
  logic [$bits(res_t)-1:0] w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [OCC_W-1:0]  w_occ;

  function automatic logic any_hit(input logic [NCHK-1:0] mask, input logic [NCHK-1:0] obs);
    return |(mask & obs);
  endfunction

  assign w_clr          = RST | sweep.abort;
  assign w_accept_start = (r_state == ST_IDLE) && sweep.start && !sweep.abort;
  assign w_pop          = sweep.res_ready && !w_fifo_empty;

  // Count results still travelling through the checker-latency pipe
  always_comb begin
    w_inflight = 3'd0;
    for (int k = 0; k <= CHK_LAT; k++) begin
      w_inflight = w_inflight + {2'b00, r_pv[k]};
    end
  end

  // A pop at this edge frees a slot in time for the new issue, which keeps full rate
  // even when FIFO_D is exactly CHK_LAT+1.
  assign w_used  = 8'(w_occ) + 8'(w_inflight);
  assign w_limit = 8'(FIFO_D) + 8'(w_pop);
  assign w_issue = (r_state == ST_SWEEP) && !sweep.abort && (w_used < w_limit);

  // Next-state logic; abort overrides every state
  always_comb begin
    w_state_seq = r_state;
    case (r_state)
      ST_IDLE: begin
        if (sweep.start) begin
          if (sweep.edge_count == CODE_W'(0)) begin
            w_state_seq = ST_FIN;
          end else begin
            w_state_seq = ST_SWEEP;
          end
        end else begin
          w_state_seq = ST_IDLE;
        end
      end
      ST_SWEEP: begin
        if (w_issue && (r_idx == last_idx(r_cnt))) begin
          w_state_seq = ST_DRAIN;
        end else begin
          w_state_seq = ST_SWEEP;
        end
      end
      ST_DRAIN: begin
        // Leave once the last result is handed off at this edge.
        if ((w_inflight == 3'd0) &&
            ((w_occ == OCC_W'(0)) || ((w_occ == OCC_W'(1)) && w_pop))) begin
          w_state_seq = ST_FIN;
        end else begin
          w_state_seq = ST_DRAIN;
        end
      end
      ST_FIN:  w_state_seq = ST_IDLE;
      default: w_state_seq = ST_IDLE;
    endcase
    w_state_nxt = sweep.abort ? ST_IDLE : w_state_seq;
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == ST_SWEEP) || (w_state_nxt == ST_DRAIN);
      r_done  <= (w_state_nxt == ST_FIN);
    end
  end

  // Sweep configuration latch and edge index counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= CODE_W'(0);
      r_obs <= '0;
      r_idx <= CODE_W'(0);
    end else if (w_accept_start) begin
      r_cnt <= sweep.edge_count;
      r_obs <= sweep.obs_en;
      r_idx <= CODE_W'(0);
    end else if (w_issue) begin
      r_idx <= r_idx + CODE_W'(1);
    end
  end

  // Edge code to the bank; holds its last value between issues
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chk_code <= CODE_W'(0);
    end else if (w_issue) begin
      r_chk_code <= r_idx;
    end
  end

  // Tag/valid shift register matching the checker-bank latency
  always_ff @(posedge CLK) begin
    if (w_clr) begin
      for (int k = 0; k <= CHK_LAT; k++) begin
        r_pv[k] <= 1'b0;
        r_pt[k] <= CODE_W'(0);
      end
    end else begin
      r_pv[0] <= w_issue;
      if (w_issue) begin
        r_pt[0] <= r_idx;
      end
      for (int k = 1; k <= CHK_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        r_pt[k] <= r_pt[k-1];
      end
    end
  end

  // Credits already rule out a push into a full FIFO; the full term only keeps the FIFO honest.
  assign w_push           = r_pv[CHK_LAT] && (!w_fifo_full || w_pop);
  assign w_res_in.addr    = r_pt[CHK_LAT];
  assign w_res_in.blocked = any_hit(sweep.chk_mask, r_obs);

  prm_res_fifo #(
    .DEPTH (FIFO_D),
    .W     ($bits(res_t)),
    .CW    (OCC_W)
  ) u_res_fifo (
    .i_clk   (CLK),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_din   (w_res_in),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_occ)
  );

  assign w_head = res_t'(w_fifo_dout);

  assign sweep.chk_code    = r_chk_code;
  assign sweep.res_valid   = !w_fifo_empty;
  assign sweep.res_addr    = w_head.addr;
  assign sweep.res_blocked = w_head.blocked;
  assign sweep.busy        = r_busy;
  assign sweep.done        = r_done;

endmodule

// File: tb/tb_prm_edge_sweep_ctrl.sv
// tb_prm_edge_sweep_ctrl
// Self-checking bench: a one-cycle-latency model of the checker bank answers chk_code, expected
// per-edge results are queued when a sweep is started and popped on every accepted result.
module tb_prm_edge_sweep_ctrl;
  import prm_sweep_pkg::*;

  localparam int NCHK    = 32;
  localparam int CHK_LAT = 1;
  localparam int FIFO_D  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  prm_edge_sweep_ctrl_if #(.NCHK(NCHK)) bus ();

  prm_edge_sweep_ctrl #(
    .NCHK    (NCHK),
    .CHK_LAT (CHK_LAT),
    .FIFO_D  (FIFO_D)
  ) dut (
    .CLK   (clk),
    .RST   (rst),
    .sweep (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Checker bank model: bit0 flags edge 2, bit5 flags every edge with code%8 == 6.
  function automatic logic [NCHK-1:0] bank_mask(input logic [CODE_W-1:0] c);
    logic [NCHK-1:0] m;
    m    = '0;
    m[0] = (c == CODE_W'(2));
    m[5] = (c[2:0] == 3'd6);
    return m;
  endfunction

  logic [CODE_W-1:0] code_d = '0;
  always @(posedge clk) code_d <= bus.chk_code;
  assign bus.chk_mask = bank_mask(code_d);

  res_t sb[$];
  int   acc_cyc[$];
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic prev_hold = 1'b0;
  res_t prev_res;

  // Output monitor: scoreboard on every handshake, hold stability while stalled, done pulses.
  always @(negedge clk) begin
    res_t e;
    if (!rst) begin
      if (prev_hold) begin
        vectors++;
        if (bus.res_valid !== 1'b1 || bus.res_addr !== prev_res.addr ||
            bus.res_blocked !== prev_res.blocked) begin
          miscompares++;
          $display("FAIL hold: got valid=%0b addr=%0d blk=%0b, need valid=1 addr=%0d blk=%0b",
                   bus.res_valid, bus.res_addr, bus.res_blocked, prev_res.addr, prev_res.blocked);
        end
      end
      if (bus.res_valid === 1'b1 && bus.res_ready === 1'b1) begin
        vectors++;
        acc_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected result: addr=%0d blk=%0b, need none", bus.res_addr, bus.res_blocked);
        end else begin
          e = sb.pop_front();
          if (bus.res_addr !== e.addr || bus.res_blocked !== e.blocked) begin
            miscompares++;
            $display("FAIL result: got addr=%0d blk=%0b, need addr=%0d blk=%0b",
                     bus.res_addr, bus.res_blocked, e.addr, e.blocked);
          end
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
    prev_hold     = (bus.res_valid === 1'b1) && (bus.res_ready === 1'b0) && (bus.abort === 1'b0) && !rst;
    prev_res.addr    = bus.res_addr;
    prev_res.blocked = bus.res_blocked;
  end

  task automatic start_sweep(input int n, input logic [NCHK-1:0] obs);
    res_t e;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.edge_count = CODE_W'(n);
    bus.obs_en     = obs;
    for (int i = 0; i < n; i++) begin
      e.addr    = CODE_W'(i);
      e.blocked = |(bank_mask(CODE_W'(i)) & obs);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.edge_count = '0;
    bus.obs_en     = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (bus.chk_code !== 15'd0) begin miscompares++; $display("FAIL reset chk_code: got %0d need 0", bus.chk_code); end
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL reset res_valid: got %0b need 0", bus.res_valid); end
    vectors++; if (bus.res_addr !== 15'd0) begin miscompares++; $display("FAIL reset res_addr: got %0d need 0", bus.res_addr); end
    vectors++; if (bus.res_blocked !== 1'b0) begin miscompares++; $display("FAIL reset res_blocked: got %0b need 0", bus.res_blocked); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %0b need 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %0b need 0", bus.done); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sweep5(input logic [NCHK-1:0] obs, input string lbl);
    bit ok;
    acc_cyc.delete();
    done_cnt = 0;
    bus.res_ready = 1'b1;
    start_sweep(5, obs);
    wait_done(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL %s timeout: done not seen, need done", lbl); end
    vectors++; if (acc_cyc.size() !== 5) begin miscompares++; $display("FAIL %s count: got %0d need 5", lbl, acc_cyc.size()); end
    if (acc_cyc.size() == 5) begin
      vectors++; if (acc_cyc[4] - acc_cyc[0] !== 4) begin miscompares++; $display("FAIL %s rate: span %0d cycles need 4", lbl, acc_cyc[4] - acc_cyc[0]); end
      vectors++; if (done_cyc !== acc_cyc[4] + 1) begin miscompares++; $display("FAIL %s done timing: got cycle %0d need %0d", lbl, done_cyc, acc_cyc[4] + 1); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL %s done pulses: got %0d need 1", lbl, done_cnt); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL %s busy after: got %0b need 0", lbl, bus.busy); end
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL %s leftover: got %0d pending need 0", lbl, sb.size()); end
  endtask

  task automatic test_stall();
    logic [CODE_W-1:0] c8;
    bit ok;
    acc_cyc.delete();
    done_cnt = 0;
    c8 = '0;
    ok = 1'b0;
    start_sweep(8, 32'h1);
    for (int t = 0; t < 80; t++) begin
      @(posedge clk); #1;
      bus.res_ready = !(t >= 3 && t <= 12);
      if (t >= 1 && bus.busy === 1'b1) begin
        vectors++;
        if (int'(bus.chk_code) > acc_cyc.size() + FIFO_D - 1) begin
          miscompares++;
          $display("FAIL stall credit: chk_code=%0d with %0d accepted, need <= %0d",
                   bus.chk_code, acc_cyc.size(), acc_cyc.size() + FIFO_D - 1);
        end
      end
      if (t == 8) c8 = bus.chk_code;
      if (t == 12) begin
        vectors++;
        if (bus.chk_code !== c8) begin miscompares++; $display("FAIL stall hold: chk_code=%0d need %0d", bus.chk_code, c8); end
      end
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (!ok) begin miscompares++; $display("FAIL stall timeout: done not seen, need done"); end
    vectors++; if (acc_cyc.size() !== 8) begin miscompares++; $display("FAIL stall count: got %0d need 8", acc_cyc.size()); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL stall done pulses: got %0d need 1", done_cnt); end
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL stall leftover: got %0d need 0", sb.size()); end
  endtask

  task automatic test_zero();
    acc_cyc.delete();
    done_cnt = 0;
    start_sweep(0, 32'h1);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL zero busy: got %0b need 0", bus.busy); end
      vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL zero res_valid: got %0b need 0", bus.res_valid); end
    end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL zero done pulses: got %0d need 1", done_cnt); end
    vectors++; if (acc_cyc.size() !== 0) begin miscompares++; $display("FAIL zero results: got %0d need 0", acc_cyc.size()); end
  endtask

  task automatic test_abort();
    bit found;
    bit ok;
    acc_cyc.delete();
    done_cnt = 0;
    found = 1'b0;
    bus.res_ready = 1'b1;
    start_sweep(100, 32'h21);
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (bus.chk_code == CODE_W'(40)) begin
        found = 1'b1;
        break;
      end
    end
    vectors++; if (!found) begin miscompares++; $display("FAIL abort reach: chk_code=%0d need 40", bus.chk_code); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort busy: got %0b need 0", bus.busy); end
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL abort res_valid: got %0b need 0", bus.res_valid); end
    repeat (5) @(negedge clk);
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL abort done pulses: got %0d need 0", done_cnt); end
    vectors++; if (bus.res_valid !== 1'b0) begin miscompares++; $display("FAIL abort idle valid: got %0b need 0", bus.res_valid); end
    sb.delete();
    acc_cyc.delete();
    start_sweep(3, 32'h21);
    wait_done(40, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL restart timeout: done not seen, need done"); end
    vectors++; if (acc_cyc.size() !== 3) begin miscompares++; $display("FAIL restart count: got %0d need 3", acc_cyc.size()); end
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL restart leftover: got %0d need 0", sb.size()); end
  endtask

  task automatic test_start_busy();
    bit ok;
    acc_cyc.delete();
    done_cnt = 0;
    bus.res_ready = 1'b1;
    start_sweep(6, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.edge_count = CODE_W'(3);
    bus.obs_en     = '1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.edge_count = '0;
    bus.obs_en     = '0;
    wait_done(60, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL busy-start timeout: done not seen, need done"); end
    vectors++; if (acc_cyc.size() !== 6) begin miscompares++; $display("FAIL busy-start count: got %0d need 6", acc_cyc.size()); end
    vectors++; if (done_cnt !== 1) begin miscompares++; $display("FAIL busy-start done pulses: got %0d need 1", done_cnt); end
    vectors++; if (sb.size() !== 0) begin miscompares++; $display("FAIL busy-start leftover: got %0d need 0", sb.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.edge_count = '0;
    bus.obs_en     = '0;
    bus.res_ready  = 1'b1;
    test_reset();
    test_sweep5(32'h1, "sweep5_obs1");
    test_sweep5(32'h0, "sweep5_obs0");
    test_stall();
    test_zero();
    test_abort();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
